// File: rtl/key_reader_bit.sv
// One debounced key bit: 2-flop synchronizer, stability counter, and
// registered edge pulses that coincide with the cycle VAL first changes.
module key_reader_bit #(
    parameter int DEBOUNCE = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic key_i,
    output logic val_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);

    logic          s1_q;
    logic          s2_q;
    logic          val_q;
    logic          val_d;
    logic          rise_q;
    logic          rise_d;
    logic          fall_q;
    logic          fall_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Any return of the synchronized level to VAL restarts the count,
    // so only an uninterrupted run of DEBOUNCE cycles is accepted.
    always_comb begin
        cnt_d  = cnt_q;
        val_d  = val_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (s2_q == val_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            val_d  = s2_q;
            cnt_d  = '0;
            rise_d = s2_q;
            fall_d = ~s2_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            cnt_q  <= '0;
            val_q  <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            s1_q   <= key_i;
            s2_q   <= s1_q;
            cnt_q  <= cnt_d;
            val_q  <= val_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign val_o  = val_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/key_reader.sv
// Debounced key/switch reader: per-bit debouncers plus a single-entry
// change-event register with valid/ready handshake and sticky overrun.
module key_reader #(
    parameter int WIDTH      = 4,
    parameter int DEBOUNCE   = 4,
    parameter int ACTIVE_LOW = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] KEY,
    output logic [WIDTH-1:0] VAL,
    output logic [WIDTH-1:0] RISE,
    output logic [WIDTH-1:0] FALL,
    output logic             EVT_VALID,
    output logic [WIDTH-1:0] EVT_DATA,
    input  logic             EVT_READY,
    output logic             OVERRUN
);

    localparam logic INVERT = (ACTIVE_LOW != 0);

    logic [WIDTH-1:0] keyIn;
    logic             change;
    logic             evt_valid_q;
    logic             evt_valid_d;
    logic [WIDTH-1:0] evt_data_q;
    logic [WIDTH-1:0] evt_data_d;
    logic             overrun_q;
    logic             overrun_d;

    assign keyIn = KEY ^ {WIDTH{INVERT}};

    key_reader_bit #(
        .DEBOUNCE(DEBOUNCE)
    ) u_bit[WIDTH-1:0] (
        .CLK   (CLK),
        .RST   (RST),
        .key_i (keyIn),
        .val_o (VAL),
        .rise_o(RISE),
        .fall_o(FALL)
    );

    // RISE/FALL mark the cycle VAL shows its new value, so the snapshot
    // taken here is the freshly updated VAL. A load always wins over
    // acceptance; it only counts as an overrun if the old event was not taken.
    assign change = |(RISE | FALL);

    always_comb begin
        evt_valid_d = evt_valid_q;
        evt_data_d  = evt_data_q;
        overrun_d   = overrun_q;
        if (change) begin
            evt_valid_d = 1'b1;
            evt_data_d  = VAL;
            if (evt_valid_q && !EVT_READY) begin
                overrun_d = 1'b1;
            end
        end else if (evt_valid_q && EVT_READY) begin
            evt_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            evt_valid_q <= 1'b0;
            evt_data_q  <= '0;
            overrun_q   <= 1'b0;
        end else begin
            evt_valid_q <= evt_valid_d;
            evt_data_q  <= evt_data_d;
            overrun_q   <= overrun_d;
        end
    end

    assign EVT_VALID = evt_valid_q;
    assign EVT_DATA  = evt_data_q;
    assign OVERRUN   = overrun_q;

endmodule

// File: tb/tb_key_reader.sv
// Self-checking bench for key_reader: an active-high-key instance drives most
// scenarios with an event scoreboard; a second instance covers ACTIVE_LOW=1.
module tb_key_reader;

    logic       CLK;
    logic       RST;
    logic [3:0] KEY;
    logic [3:0] VAL;
    logic [3:0] RISE;
    logic [3:0] FALL;
    logic       EVT_VALID;
    logic [3:0] EVT_DATA;
    logic       EVT_READY;
    logic       OVERRUN;

    logic [3:0] key2;
    logic [3:0] val2;
    logic [3:0] rise2;
    logic [3:0] fall2;
    logic       evtValid2;
    logic [3:0] evtData2;
    logic       ready2;
    logic       overrun2;

    int tests;
    int failures;
    logic [3:0] expQ[$];
    logic [3:0] expData;

    key_reader #(.WIDTH(4), .DEBOUNCE(4), .ACTIVE_LOW(0)) dut (
        .CLK(CLK), .RST(RST), .KEY(KEY), .VAL(VAL), .RISE(RISE), .FALL(FALL),
        .EVT_VALID(EVT_VALID), .EVT_DATA(EVT_DATA), .EVT_READY(EVT_READY),
        .OVERRUN(OVERRUN)
    );

    key_reader #(.WIDTH(4), .DEBOUNCE(4), .ACTIVE_LOW(1)) dutLow (
        .CLK(CLK), .RST(RST), .KEY(key2), .VAL(val2), .RISE(rise2), .FALL(fall2),
        .EVT_VALID(evtValid2), .EVT_DATA(evtData2), .EVT_READY(ready2),
        .OVERRUN(overrun2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic popExpected();
        if (expQ.size() == 0) begin
            expData = 4'hx;
        end else begin
            expData = expQ.pop_front();
        end
    endtask

    task automatic test_reset();
        RST = 1'b0; KEY = 4'b0000; key2 = 4'b1111; EVT_READY = 1'b0; ready2 = 1'b1;
        #3;
        tick(); tick();
        tests++; if (VAL !== 4'b0000) begin failures++; $display("[TB] FAIL reset_val got %b expected 0000", VAL); end
        tests++; if (RISE !== 4'b0000) begin failures++; $display("[TB] FAIL reset_rise got %b expected 0000", RISE); end
        tests++; if (FALL !== 4'b0000) begin failures++; $display("[TB] FAIL reset_fall got %b expected 0000", FALL); end
        tests++; if (EVT_VALID !== 1'b0) begin failures++; $display("[TB] FAIL reset_evt_valid got %b expected 0", EVT_VALID); end
        tests++; if (EVT_DATA !== 4'b0000) begin failures++; $display("[TB] FAIL reset_evt_data got %b expected 0000", EVT_DATA); end
        tests++; if (OVERRUN !== 1'b0) begin failures++; $display("[TB] FAIL reset_overrun got %b expected 0", OVERRUN); end
        tests++; if (val2 !== 4'b0000) begin failures++; $display("[TB] FAIL reset_val_low got %b expected 0000", val2); end
        RST = 1'b1;
        tick(); tick();
    endtask

    task automatic test_debounce_rise();
        KEY = 4'b0001;
        expQ.push_back(4'b0001);
        for (int i = 1; i <= 6; i++) begin
            tick();
            tests++;
            if (VAL !== ((i == 6) ? 4'b0001 : 4'b0000)) begin
                failures++; $display("[TB] FAIL rise_val_edge%0d got %b expected %b", i, VAL, (i == 6) ? 4'b0001 : 4'b0000);
            end
        end
        tests++; if (RISE !== 4'b0001) begin failures++; $display("[TB] FAIL rise_pulse got %b expected 0001", RISE); end
        tests++; if (EVT_VALID !== 1'b0) begin failures++; $display("[TB] FAIL rise_evt_early got %b expected 0", EVT_VALID); end
        tick();
        popExpected();
        tests++; if (RISE !== 4'b0000) begin failures++; $display("[TB] FAIL rise_pulse_end got %b expected 0000", RISE); end
        tests++; if (EVT_VALID !== 1'b1) begin failures++; $display("[TB] FAIL rise_evt_valid got %b expected 1", EVT_VALID); end
        tests++; if (EVT_DATA !== expData) begin failures++; $display("[TB] FAIL rise_evt_data got %b expected %b", EVT_DATA, expData); end
        EVT_READY = 1'b1;
        tick();
        EVT_READY = 1'b0;
        tests++; if (EVT_VALID !== 1'b0) begin failures++; $display("[TB] FAIL rise_accept got %b expected 0", EVT_VALID); end
        tests++; if (OVERRUN !== 1'b0) begin failures++; $display("[TB] FAIL rise_overrun got %b expected 0", OVERRUN); end
    endtask

    task automatic test_glitch();
        KEY = 4'b0101;
        tick(); tick(); tick();
        KEY = 4'b0001;
        for (int i = 1; i <= 8; i++) begin
            tick();
            tests++;
            if (VAL !== 4'b0001 || RISE !== 4'b0000 || FALL !== 4'b0000 || EVT_VALID !== 1'b0) begin
                failures++;
                $display("[TB] FAIL glitch_cycle%0d got val=%b rise=%b fall=%b valid=%b expected val=0001 rise=0000 fall=0000 valid=0",
                         i, VAL, RISE, FALL, EVT_VALID);
            end
        end
    endtask

    task automatic test_fall();
        KEY = 4'b0000;
        expQ.push_back(4'b0000);
        EVT_READY = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            tests++;
            if (VAL !== ((i == 6) ? 4'b0000 : 4'b0001)) begin
                failures++; $display("[TB] FAIL fall_val_edge%0d got %b expected %b", i, VAL, (i == 6) ? 4'b0000 : 4'b0001);
            end
        end
        tests++; if (FALL !== 4'b0001 || RISE !== 4'b0000) begin failures++; $display("[TB] FAIL fall_pulse got fall=%b rise=%b expected fall=0001 rise=0000", FALL, RISE); end
        tick();
        popExpected();
        tests++; if (EVT_VALID !== 1'b1 || EVT_DATA !== expData) begin failures++; $display("[TB] FAIL fall_evt got valid=%b data=%b expected valid=1 data=%b", EVT_VALID, EVT_DATA, expData); end
        tick();
        tests++; if (EVT_VALID !== 1'b0) begin failures++; $display("[TB] FAIL fall_accept got %b expected 0", EVT_VALID); end
        EVT_READY = 1'b0;
    endtask

    task automatic test_back_to_back();
        EVT_READY = 1'b1;
        KEY = 4'b0010;
        expQ.push_back(4'b0010);
        tick();
        KEY = 4'b1010;
        expQ.push_back(4'b1010);
        for (int i = 2; i <= 5; i++) tick();
        tick();
        tests++; if (VAL !== 4'b0010 || RISE !== 4'b0010) begin failures++; $display("[TB] FAIL b2b_first got val=%b rise=%b expected val=0010 rise=0010", VAL, RISE); end
        tick();
        popExpected();
        tests++; if (VAL !== 4'b1010 || RISE !== 4'b1000) begin failures++; $display("[TB] FAIL b2b_second got val=%b rise=%b expected val=1010 rise=1000", VAL, RISE); end
        tests++; if (EVT_VALID !== 1'b1 || EVT_DATA !== expData) begin failures++; $display("[TB] FAIL b2b_evt1 got valid=%b data=%b expected valid=1 data=%b", EVT_VALID, EVT_DATA, expData); end
        tick();
        popExpected();
        tests++; if (EVT_VALID !== 1'b1 || EVT_DATA !== expData) begin failures++; $display("[TB] FAIL b2b_evt2 got valid=%b data=%b expected valid=1 data=%b", EVT_VALID, EVT_DATA, expData); end
        tests++; if (OVERRUN !== 1'b0) begin failures++; $display("[TB] FAIL b2b_overrun got %b expected 0", OVERRUN); end
        tick();
        tests++; if (EVT_VALID !== 1'b0) begin failures++; $display("[TB] FAIL b2b_drain got %b expected 0", EVT_VALID); end
        EVT_READY = 1'b0;
    endtask

    task automatic test_overrun();
        logic [3:0] firstData;
        EVT_READY = 1'b0;
        KEY = 4'b1000;
        expQ.push_back(4'b1000);
        for (int i = 1; i <= 7; i++) tick();
        popExpected();
        firstData = expData;
        tests++; if (EVT_VALID !== 1'b1 || EVT_DATA !== firstData) begin failures++; $display("[TB] FAIL ovr_evt1 got valid=%b data=%b expected valid=1 data=%b", EVT_VALID, EVT_DATA, firstData); end
        tests++; if (OVERRUN !== 1'b0) begin failures++; $display("[TB] FAIL ovr_early got %b expected 0", OVERRUN); end
        KEY = 4'b0000;
        expQ.push_back(4'b0000);
        for (int i = 1; i <= 6; i++) tick();
        tests++; if (EVT_DATA !== firstData || EVT_VALID !== 1'b1) begin failures++; $display("[TB] FAIL ovr_hold got valid=%b data=%b expected valid=1 data=%b", EVT_VALID, EVT_DATA, firstData); end
        tick();
        popExpected();
        tests++; if (EVT_VALID !== 1'b1 || EVT_DATA !== expData) begin failures++; $display("[TB] FAIL ovr_evt2 got valid=%b data=%b expected valid=1 data=%b", EVT_VALID, EVT_DATA, expData); end
        tests++; if (OVERRUN !== 1'b1) begin failures++; $display("[TB] FAIL ovr_set got %b expected 1", OVERRUN); end
        EVT_READY = 1'b1;
        tick();
        EVT_READY = 1'b0;
        tests++; if (EVT_VALID !== 1'b0 || OVERRUN !== 1'b1) begin failures++; $display("[TB] FAIL ovr_accept got valid=%b overrun=%b expected valid=0 overrun=1", EVT_VALID, OVERRUN); end
        tick(); tick();
        tests++; if (OVERRUN !== 1'b1) begin failures++; $display("[TB] FAIL ovr_sticky got %b expected 1", OVERRUN); end
    endtask

    task automatic test_active_low();
        tick();
        tests++; if (val2 !== 4'b0000 || evtValid2 !== 1'b0) begin failures++; $display("[TB] FAIL low_idle got val=%b valid=%b expected val=0000 valid=0", val2, evtValid2); end
        key2 = 4'b0111;
        for (int i = 1; i <= 6; i++) begin
            tick();
            tests++;
            if (val2 !== ((i == 6) ? 4'b1000 : 4'b0000)) begin
                failures++; $display("[TB] FAIL low_val_edge%0d got %b expected %b", i, val2, (i == 6) ? 4'b1000 : 4'b0000);
            end
        end
        tests++; if (rise2 !== 4'b1000) begin failures++; $display("[TB] FAIL low_rise got %b expected 1000", rise2); end
        tick();
        tests++; if (evtValid2 !== 1'b1 || evtData2 !== 4'b1000) begin failures++; $display("[TB] FAIL low_evt got valid=%b data=%b expected valid=1 data=1000", evtValid2, evtData2); end
        tick();
        tests++; if (evtValid2 !== 1'b0) begin failures++; $display("[TB] FAIL low_accept got %b expected 0", evtValid2); end
    endtask

    task automatic test_reset_midcount();
        KEY = 4'b0100;
        tick(); tick(); tick(); tick();
        RST = 1'b0;
        #1;
        tests++; if (VAL !== 4'b0000 || RISE !== 4'b0000 || FALL !== 4'b0000) begin failures++; $display("[TB] FAIL mid_reset_bits got val=%b rise=%b fall=%b expected all 0000", VAL, RISE, FALL); end
        tests++; if (EVT_VALID !== 1'b0 || EVT_DATA !== 4'b0000 || OVERRUN !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset_evt got valid=%b data=%b overrun=%b expected 0 0000 0", EVT_VALID, EVT_DATA, OVERRUN); end
        tests++; if (val2 !== 4'b0000) begin failures++; $display("[TB] FAIL mid_reset_val_low got %b expected 0000", val2); end
        tick(); tick();
        RST = 1'b1;
        expQ.push_back(4'b0100);
        for (int i = 1; i <= 6; i++) begin
            tick();
            tests++;
            if (VAL !== ((i == 6) ? 4'b0100 : 4'b0000)) begin
                failures++; $display("[TB] FAIL mid_val_edge%0d got %b expected %b", i, VAL, (i == 6) ? 4'b0100 : 4'b0000);
            end
        end
        tests++; if (RISE !== 4'b0100) begin failures++; $display("[TB] FAIL mid_rise got %b expected 0100", RISE); end
        tick();
        popExpected();
        tests++; if (EVT_VALID !== 1'b1 || EVT_DATA !== expData) begin failures++; $display("[TB] FAIL mid_evt got valid=%b data=%b expected valid=1 data=%b", EVT_VALID, EVT_DATA, expData); end
    endtask

    initial begin
        tests = 0;
        failures = 0;
        test_reset();
        test_debounce_rise();
        test_glitch();
        test_fall();
        test_back_to_back();
        test_overrun();
        test_active_low();
        test_reset_midcount();
        tests++;
        if (expQ.size() != 0) begin
            failures++; $display("[TB] FAIL scoreboard_drain got %0d entries expected 0", expQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
